// File: rtl/sal_ddr_pkg.sv
// Shared types and default timing for the DDR2 bank controllers.
// Define SAL_DDR_PARAMS to take row/column widths from DRAM_RA_WIDTH / DRAM_CA_WIDTH.
`ifdef SAL_DDR_PARAMS
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`endif

package sal_ddr_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_type_e;

  typedef enum logic [0:0] {
    BK_CLOSED = 1'b0,
    BK_OPEN   = 1'b1
  } bk_state_e;

  localparam int unsigned DDR_ID_W  = 4;
`ifdef SAL_DDR_PARAMS
  localparam int unsigned DDR_RA_W  = `DRAM_RA_WIDTH;
  localparam int unsigned DDR_CA_W  = `DRAM_CA_WIDTH;
`else
  localparam int unsigned DDR_RA_W  = 14;
  localparam int unsigned DDR_CA_W  = 10;
`endif
  localparam int unsigned DDR_LEN_W = 4;

  localparam int unsigned DEF_T_RCD = 3;
  localparam int unsigned DEF_T_RP  = 3;
  localparam int unsigned DEF_T_RAS = 8;
  localparam int unsigned DEF_T_RTP = 2;
  localparam int unsigned DEF_T_WTP = 6;

  // Counter width wide enough for the largest timing value plus one bit.
  function automatic int unsigned cnt_width(input int unsigned t_rcd, input int unsigned t_rp,
                                            input int unsigned t_ras, input int unsigned t_rtp,
                                            input int unsigned t_wtp);
    int unsigned m;
    m = t_rcd;
    if (t_rp  > m) m = t_rp;
    if (t_ras > m) m = t_ras;
    if (t_rtp > m) m = t_rtp;
    if (t_wtp > m) m = t_wtp;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sal_timing_cnt.sv
// Loadable down-counter that saturates at zero; zero_next_c shows whether the
// count will read zero in the following cycle.
module sal_timing_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         is_zero,
  output logic         zero_next_c
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (load) begin
      cnt_n = load_val;
    end else if (cnt != '0) begin
      cnt_n = cnt - W'(1);
    end
  end

  assign zero_next_c = (cnt_n == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      is_zero <= 1'b1;
    end else begin
      cnt     <= cnt_n;
      is_zero <= zero_next_c;
    end
  end

endmodule

// File: rtl/sal_bk_ctrl.sv
// Per-bank DDR2 controller: single-entry request buffer, open-row tracking, ACT/RD/WR/PRE issue.
// Define SAL_BK_CLOSED_PAGE_EN for closed-page policy (precharge an idle open row).
module sal_bk_ctrl
  import sal_ddr_pkg::*;
#(
  parameter int unsigned ID_W  = DDR_ID_W,
  parameter int unsigned RA_W  = DDR_RA_W,
  parameter int unsigned CA_W  = DDR_CA_W,
  parameter int unsigned LEN_W = DDR_LEN_W,
  parameter int unsigned T_RCD = DEF_T_RCD,
  parameter int unsigned T_RP  = DEF_T_RP,
  parameter int unsigned T_RAS = DEF_T_RAS,
  parameter int unsigned T_RTP = DEF_T_RTP,
  parameter int unsigned T_WTP = DEF_T_WTP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ID_W-1:0]  req_id,
  input  logic [RA_W-1:0]  req_ra,
  input  logic [CA_W-1:0]  req_ca,
  input  logic [LEN_W-1:0] req_len,
  input  logic             req_wr,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_type,
  output logic [RA_W-1:0]  cmd_ra,
  output logic [CA_W-1:0]  cmd_ca,
  output logic [ID_W-1:0]  cmd_id,
  output logic [LEN_W-1:0] cmd_len
);

  localparam int unsigned CNT_W     = cnt_width(T_RCD, T_RP, T_RAS, T_RTP, T_WTP);
  localparam logic [0:0]  ST_CLOSED = BK_CLOSED;
  localparam logic [0:0]  ST_OPEN   = BK_OPEN;

  logic [0:0]       state_q, state_n;
  logic [RA_W-1:0]  open_row_q, open_row_n;
  logic             buf_valid_q, buf_valid_n;
  logic [RA_W-1:0]  buf_ra_q, buf_ra_n;
  logic [CA_W-1:0]  buf_ca_q, buf_ca_n;
  logic [ID_W-1:0]  buf_id_q, buf_id_n;
  logic [LEN_W-1:0] buf_len_q, buf_len_n;
  logic             buf_wr_q, buf_wr_n;

  logic             cmd_valid_n;
  logic [1:0]       cmd_type_n;
  logic [RA_W-1:0]  cmd_ra_n;
  logic [CA_W-1:0]  cmd_ca_n;
  logic [ID_W-1:0]  cmd_id_n;
  logic [LEN_W-1:0] cmd_len_n;

  logic cmd_hs, req_hs, act_hs, rw_hs, pre_hs;
  logic rcd_zero, rp_zero, ras_zero, pre_zero;
  logic rcd_zero_n, rp_zero_n, ras_zero_n, pre_zero_n;
  logic [CNT_W-1:0] pre_load_val;
  logic unused_cnt_flags;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign req_hs = req_valid && req_ready;
  assign act_hs = cmd_hs && (cmd_type == CMD_ACT);
  assign rw_hs  = cmd_hs && ((cmd_type == CMD_RD) || (cmd_type == CMD_WR));
  assign pre_hs = cmd_hs && (cmd_type == CMD_PRE);
  assign pre_load_val = (cmd_type == CMD_WR) ? CNT_W'(T_WTP - 1) : CNT_W'(T_RTP - 1);

  // Scheduling looks ahead at the next-cycle counter values; the current flags are not needed.
  assign unused_cnt_flags = ^{rcd_zero, rp_zero, ras_zero, pre_zero};

  sal_timing_cnt #(.W(CNT_W)) u_cnt_rcd (
    .clk(clk), .rst(rst), .load(act_hs), .load_val(CNT_W'(T_RCD - 1)),
    .is_zero(rcd_zero), .zero_next_c(rcd_zero_n)
  );

  sal_timing_cnt #(.W(CNT_W)) u_cnt_ras (
    .clk(clk), .rst(rst), .load(act_hs), .load_val(CNT_W'(T_RAS - 1)),
    .is_zero(ras_zero), .zero_next_c(ras_zero_n)
  );

  sal_timing_cnt #(.W(CNT_W)) u_cnt_rp (
    .clk(clk), .rst(rst), .load(pre_hs), .load_val(CNT_W'(T_RP - 1)),
    .is_zero(rp_zero), .zero_next_c(rp_zero_n)
  );

  sal_timing_cnt #(.W(CNT_W)) u_cnt_pre (
    .clk(clk), .rst(rst), .load(rw_hs), .load_val(pre_load_val),
    .is_zero(pre_zero), .zero_next_c(pre_zero_n)
  );

  // Next bank/buffer state, then the command to present next cycle from that state.
  always_comb begin
    state_n     = state_q;
    open_row_n  = open_row_q;
    buf_valid_n = buf_valid_q;
    buf_ra_n    = buf_ra_q;
    buf_ca_n    = buf_ca_q;
    buf_id_n    = buf_id_q;
    buf_len_n   = buf_len_q;
    buf_wr_n    = buf_wr_q;
    cmd_valid_n = 1'b0;
    cmd_type_n  = CMD_ACT;
    cmd_ra_n    = '0;
    cmd_ca_n    = '0;
    cmd_id_n    = '0;
    cmd_len_n   = '0;

    if (act_hs) begin
      state_n    = ST_OPEN;
      open_row_n = buf_ra_q;
    end
    if (pre_hs) begin
      state_n = ST_CLOSED;
    end
    if (rw_hs) begin
      buf_valid_n = 1'b0;
    end
    if (req_hs) begin
      buf_valid_n = 1'b1;
      buf_ra_n    = req_ra;
      buf_ca_n    = req_ca;
      buf_id_n    = req_id;
      buf_len_n   = req_len;
      buf_wr_n    = req_wr;
    end

    if (cmd_valid && !cmd_ready) begin
      cmd_valid_n = 1'b1;
      cmd_type_n  = cmd_type;
      cmd_ra_n    = cmd_ra;
      cmd_ca_n    = cmd_ca;
      cmd_id_n    = cmd_id;
      cmd_len_n   = cmd_len;
    end else if (buf_valid_n) begin
      if (state_n == ST_CLOSED) begin
        if (rp_zero_n) begin
          cmd_valid_n = 1'b1;
          cmd_type_n  = CMD_ACT;
          cmd_ra_n    = buf_ra_n;
        end
      end else if (buf_ra_n == open_row_n) begin
        if (rcd_zero_n) begin
          cmd_valid_n = 1'b1;
          cmd_type_n  = buf_wr_n ? CMD_WR : CMD_RD;
          cmd_ca_n    = buf_ca_n;
          cmd_id_n    = buf_id_n;
          cmd_len_n   = buf_len_n;
        end
      end else if (ras_zero_n && pre_zero_n) begin
        cmd_valid_n = 1'b1;
        cmd_type_n  = CMD_PRE;
      end
    end
`ifdef SAL_BK_CLOSED_PAGE_EN
    else if ((state_n == ST_OPEN) && ras_zero_n && pre_zero_n) begin
      cmd_valid_n = 1'b1;
      cmd_type_n  = CMD_PRE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLOSED;
      open_row_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_ra_q    <= '0;
      buf_ca_q    <= '0;
      buf_id_q    <= '0;
      buf_len_q   <= '0;
      buf_wr_q    <= 1'b0;
      req_ready   <= 1'b1;
      cmd_valid   <= 1'b0;
      cmd_type    <= '0;
      cmd_ra      <= '0;
      cmd_ca      <= '0;
      cmd_id      <= '0;
      cmd_len     <= '0;
    end else begin
      state_q     <= state_n;
      open_row_q  <= open_row_n;
      buf_valid_q <= buf_valid_n;
      buf_ra_q    <= buf_ra_n;
      buf_ca_q    <= buf_ca_n;
      buf_id_q    <= buf_id_n;
      buf_len_q   <= buf_len_n;
      buf_wr_q    <= buf_wr_n;
      req_ready   <= !buf_valid_n;
      cmd_valid   <= cmd_valid_n;
      cmd_type    <= cmd_type_n;
      cmd_ra      <= cmd_ra_n;
      cmd_ca      <= cmd_ca_n;
      cmd_id      <= cmd_id_n;
      cmd_len     <= cmd_len_n;
    end
  end

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Scoreboard bench for sal_bk_ctrl (default open-page build): directed requests push
// expected commands with their handshake cycle; a monitor pops and checks them.
module tb_sal_bk_ctrl;

  localparam logic [1:0] T_ACT = 2'd0;
  localparam logic [1:0] T_RD  = 2'd1;
  localparam logic [1:0] T_WR  = 2'd2;
  localparam logic [1:0] T_PRE = 2'd3;

  typedef struct {
    logic [1:0]  t;
    logic [13:0] ra;
    logic [9:0]  ca;
    logic [3:0]  id;
    logic [3:0]  len;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_id;
  logic [13:0] req_ra;
  logic [9:0]  req_ca;
  logic [3:0]  req_len;
  logic        req_wr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [13:0] cmd_ra;
  logic [9:0]  cmd_ca;
  logic [3:0]  cmd_id;
  logic [3:0]  cmd_len;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  sal_bk_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_ra(req_ra),
    .req_ca(req_ca), .req_len(req_len), .req_wr(req_wr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_ra(cmd_ra),
    .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [1:0] t, input logic [13:0] ra, input logic [9:0] ca,
                      input logic [3:0] id, input logic [3:0] len, input int c);
    exp_t e;
    e.t = t; e.ra = ra; e.ca = ca; e.id = id; e.len = len; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (cyc >= c) break;
    end
  endtask

  // Raise a request and wait for acceptance; acc is the cycle of the accepting edge.
  task automatic begin_req(input logic [13:0] ra, input logic [9:0] ca, input logic [3:0] id,
                           input logic [3:0] len, input logic wr, output int acc);
    tick();
    req_valid = 1'b1;
    req_ra = ra; req_ca = ca; req_id = id; req_len = len; req_wr = wr;
    acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_accept_timeout: req_ready=%0b, required 1 within 200 cycles", req_ready);
    end
  endtask

  task automatic end_req();
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_cmd_type",  32'(cmd_type),  0);
    chk("rst_cmd_ra",    32'(cmd_ra),    0);
    chk("rst_cmd_ca",    32'(cmd_ca),    0);
    chk("rst_cmd_id",    32'(cmd_id),    0);
    chk("rst_cmd_len",   32'(cmd_len),   0);
    exp_q.delete();
  endtask

  // Monitor: every command handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_cmd: got type %0d ra 0x%0h id %0d at cycle %0d, required none",
                   cmd_type, cmd_ra, cmd_id, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_type",  32'(cmd_type), 32'(e.t));
          chk("cmd_cycle", 32'(cyc),      32'(e.cyc));
          if (e.t == T_ACT) begin
            chk("cmd_ra", 32'(cmd_ra), 32'(e.ra));
          end else if (e.t == T_RD || e.t == T_WR) begin
            chk("cmd_ca",  32'(cmd_ca),  32'(e.ca));
            chk("cmd_id",  32'(cmd_id),  32'(e.id));
            chk("cmd_len", 32'(cmd_len), 32'(e.len));
          end
        end
      end
    end
  end

  initial begin
    int a, a2, b, t, w;
    rst = 1'b1; req_valid = 1'b0; cmd_ready = 1'b1;
    req_id = '0; req_ra = '0; req_ca = '0; req_len = '0; req_wr = 1'b0;

    // 1: cold read -> ACT, RD after tRCD, buffer free the cycle after RD
    do_reset();
    begin_req(14'h012, 10'h040, 4'd3, 4'd4, 1'b0, a);
    t = a + 1;
    push(T_ACT, 14'h012, 10'h000, 4'd0, 4'd0, t);
    push(T_RD,  14'h000, 10'h040, 4'd3, 4'd4, t + 3);
    end_req();
    wait_cyc(t + 3);
    chk("t1_req_ready_busy", 32'(req_ready), 0);
    wait_cyc(t + 4);
    chk("t1_req_ready_free", 32'(req_ready), 1);

    // 2: row hit -> RD directly, one cycle after accept
    begin_req(14'h012, 10'h080, 4'd5, 4'd2, 1'b0, b);
    push(T_RD, 14'h000, 10'h080, 4'd5, 4'd2, b + 1);
    end_req();
    drain();

    // 3: miss right after an ACT -> PRE gated by tRAS, then tRP, then tRCD
    do_reset();
    begin_req(14'h012, 10'h001, 4'd1, 4'd4, 1'b0, a);
    t = a + 1;
    push(T_ACT, 14'h012, 10'h000, 4'd0, 4'd0, t);
    push(T_RD,  14'h000, 10'h001, 4'd1, 4'd4, t + 3);
    end_req();
    begin_req(14'h013, 10'h002, 4'd2, 4'd4, 1'b0, a2);
    chk("t3_accept_cycle", 32'(a2), 32'(t + 4));
    push(T_PRE, 14'h000, 10'h000, 4'd0, 4'd0, t + 8);
    push(T_ACT, 14'h013, 10'h000, 4'd0, 4'd0, t + 11);
    push(T_RD,  14'h000, 10'h002, 4'd2, 4'd4, t + 14);
    end_req();
    drain();

    // 4: write then miss -> PRE gated by write-to-precharge
    do_reset();
    begin_req(14'h020, 10'h010, 4'd7, 4'd8, 1'b1, a);
    w = a + 4;
    push(T_ACT, 14'h020, 10'h000, 4'd0, 4'd0, a + 1);
    push(T_WR,  14'h000, 10'h010, 4'd7, 4'd8, w);
    end_req();
    begin_req(14'h021, 10'h011, 4'd8, 4'd4, 1'b0, a2);
    chk("t4_accept_cycle", 32'(a2), 32'(w + 1));
    push(T_PRE, 14'h000, 10'h000, 4'd0, 4'd0, w + 6);
    push(T_ACT, 14'h021, 10'h000, 4'd0, 4'd0, w + 9);
    push(T_RD,  14'h000, 10'h011, 4'd8, 4'd4, w + 12);
    end_req();
    drain();

    // 5: backpressure on ACT -> command held stable, single ACT on release
    do_reset();
    tick();
    cmd_ready = 1'b0;
    begin_req(14'h055, 10'h020, 4'd4, 4'd4, 1'b0, a);
    end_req();
    for (int k = 1; k <= 5; k++) begin
      wait_cyc(a + k);
      chk("t5_hold_valid",     32'(cmd_valid), 1);
      chk("t5_hold_type",      32'(cmd_type),  32'(T_ACT));
      chk("t5_hold_ra",        32'(cmd_ra),    'h055);
      chk("t5_hold_req_ready", 32'(req_ready), 0);
    end
    push(T_ACT, 14'h055, 10'h000, 4'd0, 4'd0, a + 6);
    push(T_RD,  14'h000, 10'h020, 4'd4, 4'd4, a + 9);
    tick();
    cmd_ready = 1'b1;
    drain();

    // 6: reset during tRCD discards the buffered read
    do_reset();
    begin_req(14'h066, 10'h030, 4'd9, 4'd4, 1'b0, a);
    push(T_ACT, 14'h066, 10'h000, 4'd0, 4'd0, a + 1);
    end_req();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cmd_valid",   32'(cmd_valid), 0);
    chk("t6_req_ready",   32'(req_ready), 1);
    chk("t6_queue_empty", 32'(exp_q.size()), 0);
    begin_req(14'h066, 10'h031, 4'd10, 4'd4, 1'b0, b);
    push(T_ACT, 14'h066, 10'h000, 4'd0,  4'd0, b + 1);
    push(T_RD,  14'h000, 10'h031, 4'd10, 4'd4, b + 4);
    end_req();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
